// File: rtl/aes_lane_packer.sv
// aes_lane_packer: gathers consecutive 128-bit plaintext blocks into one wide
// word for the parallel AES lanes. A gather buffer collects lanes; a single
// output register presents sealed words. When the output register is stalled,
// the gather buffer keeps one sealed word as a stall slot and input is paused.
module aes_lane_packer #(
  parameter int LANES = 32,
  parameter int BLK_W = 128
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [BLK_W-1:0]       in_data,
  input  logic                   in_last,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*BLK_W-1:0] out_data,
  output logic [LANES-1:0]       out_mask,
  output logic                   out_last
);

  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

  logic [LANES*BLK_W-1:0] gData;
  logic [LANES-1:0]       gMask;
  logic                   gLast;
  logic [IDX_W-1:0]       idx;
  logic                   pend;

  logic [LANES*BLK_W-1:0] mergedData;
  logic [LANES-1:0]       mergedMask;
  logic                   mergedLast;

  logic accept;
  logic sealBeat;
  logic sealFlush;
  logic seal;
  logic oFree;
  logic loadFromG;
  logic loadFromSeal;
  logic holdSeal;

  // Handshake and seal decisions; in_ready depends on the stall slot only.
  always_comb begin
    in_ready     = !pend;
    accept       = in_valid && !pend;
    sealBeat     = accept && ((idx == LAST_IDX) || in_last);
    sealFlush    = flush && !pend && ((|gMask) || accept);
    seal         = sealBeat || sealFlush;
    oFree        = !out_valid || out_ready;
    loadFromG    = pend && out_valid && out_ready;
    loadFromSeal = seal && oFree;
    holdSeal     = seal && !oFree;
    mergedLast   = accept && in_last;
  end

  // Merge the current beat (if any) into the gather buffer at lane idx.
  always_comb begin
    mergedData = gData;
    mergedMask = gMask;
    for (int k = 0; k < LANES; k++) begin
      if (accept && (idx == IDX_W'(k))) begin
        mergedData[k*BLK_W +: BLK_W] = in_data;
        mergedMask[k]                = 1'b1;
      end
    end
  end

  // Gather buffer, lane index and stall slot flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gData <= '0;
      gMask <= '0;
      gLast <= 1'b0;
      idx   <= '0;
      pend  <= 1'b0;
    end else if (loadFromG || loadFromSeal) begin
      gData <= '0;
      gMask <= '0;
      gLast <= 1'b0;
      idx   <= '0;
      pend  <= 1'b0;
    end else if (holdSeal) begin
      gData <= mergedData;
      gMask <= mergedMask;
      gLast <= mergedLast;
      pend  <= 1'b1;
    end else if (accept) begin
      gData <= mergedData;
      gMask <= mergedMask;
      idx   <= idx + 1'b1;
    end
  end

  // Output register: loads from the stall slot first, else from a fresh seal.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_mask  <= '0;
      out_last  <= 1'b0;
    end else if (loadFromG) begin
      out_valid <= 1'b1;
      out_data  <= gData;
      out_mask  <= gMask;
      out_last  <= gLast;
    end else if (loadFromSeal) begin
      out_valid <= 1'b1;
      out_data  <= mergedData;
      out_mask  <= mergedMask;
      out_last  <= mergedLast;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_aes_lane_packer.sv
// tb_aes_lane_packer: directed and randomized checks of the lane packer
// against a queue-based model of sealed words awaiting the downstream.
module tb_aes_lane_packer;

  localparam int LANES  = 32;
  localparam int BLK_W  = 128;
  localparam int WORD_W = LANES * BLK_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [BLK_W-1:0]  in_data = '0;
  logic              in_last = 1'b0;
  logic              flush = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [WORD_W-1:0] out_data;
  logic [LANES-1:0]  out_mask;
  logic              out_last;

  int testsRun = 0;
  int failCount = 0;

  typedef struct {
    logic [WORD_W-1:0] data;
    logic [LANES-1:0]  mask;
    logic              last;
  } wordT;

  wordT             expQ[$];
  logic [BLK_W-1:0] curBlocks[$];

  // Free-running clock.
  always #5 clk = ~clk;

  aes_lane_packer #(.LANES(LANES), .BLK_W(BLK_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_mask(out_mask), .out_last(out_last)
  );

  function automatic int firstBadLane(input logic [WORD_W-1:0] a, input logic [WORD_W-1:0] b);
    for (int k = 0; k < LANES; k++)
      if (a[k*BLK_W +: BLK_W] !== b[k*BLK_W +: BLK_W]) return k;
    return 0;
  endfunction

  function automatic wordT buildWord(input logic lastFlag);
    wordT w;
    w.data = '0;
    w.mask = '0;
    w.last = lastFlag;
    for (int k = 0; k < curBlocks.size(); k++) begin
      w.data[k*BLK_W +: BLK_W] = curBlocks[k];
      w.mask[k] = 1'b1;
    end
    return w;
  endfunction

  function automatic logic [BLK_W-1:0] randBlock();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkWord(input string tag, input logic [WORD_W-1:0] exp);
    int lane;
    testsRun++;
    assert (out_data === exp) else begin
      failCount++;
      lane = firstBadLane(out_data, exp);
      $error("[TB] FAIL %s lane %0d: observed %h expected %h", tag, lane,
             out_data[lane*BLK_W +: BLK_W], exp[lane*BLK_W +: BLK_W]);
    end
  endtask

  // Check outputs mid-cycle, then advance the model over the coming edge.
  task automatic modelCycle();
    logic hasWord, canTake, acc, sealNow, lastNow;
    @(negedge clk);
    hasWord = (expQ.size() > 0);
    canTake = (expQ.size() < 2);
    checkOutput("outValid", 128'(out_valid), 128'(hasWord));
    checkOutput("inReady", 128'(in_ready), 128'(canTake));
    if (hasWord) begin
      checkWord("outData", expQ[0].data);
      checkOutput("outMask", 128'(out_mask), 128'(expQ[0].mask));
      checkOutput("outLast", 128'(out_last), 128'(expQ[0].last));
    end
    acc = in_valid && canTake;
    sealNow = 1'b0;
    lastNow = 1'b0;
    if (acc) begin
      curBlocks.push_back(in_data);
      if (curBlocks.size() == LANES || in_last) begin
        sealNow = 1'b1;
        lastNow = in_last;
      end
    end
    if (!sealNow && flush && canTake && curBlocks.size() > 0) sealNow = 1'b1;
    if (hasWord && out_ready) void'(expQ.pop_front());
    if (sealNow) begin
      expQ.push_back(buildWord(lastNow));
      curBlocks.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [BLK_W-1:0] d, input logic l,
                               input logic f, input logic r);
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    flush     = f;
    out_ready = r;
    modelCycle();
  endtask

  // Directed sequence followed by a randomized soak and a reset scenario.
  initial begin
    #2;
    checkOutput("rstValid", 128'(out_valid), 128'(0));
    checkOutput("rstMask", 128'(out_mask), 128'(0));
    checkOutput("rstLast", 128'(out_last), 128'(0));
    checkOutput("rstReady", 128'(in_ready), 128'(1));
    checkWord("rstData", '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int k = 0; k < 32; k++) applyStimulus(1'b1, 128'(k), 1'b0, 1'b0, 1'b1);
    checkOutput("fullMask", 128'(out_mask), 128'hFFFF_FFFF);
    checkOutput("fullLast", 128'(out_last), 128'(0));
    checkOutput("fullLane5", out_data[5*BLK_W +: BLK_W], 128'(5));

    for (int k = 0; k < 5; k++) applyStimulus(1'b1, randBlock(), (k == 4), 1'b0, 1'b1);
    checkOutput("lastMask", 128'(out_mask), 128'h1F);
    checkOutput("lastFlag", 128'(out_last), 128'(1));

    for (int k = 0; k < 3; k++) applyStimulus(1'b1, randBlock(), 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1);
    checkOutput("flushMask", 128'(out_mask), 128'h7);
    checkOutput("flushLast", 128'(out_last), 128'(0));
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1);
    checkOutput("flushEmpty", 128'(out_valid), 128'(0));
    for (int k = 0; k < 2; k++) applyStimulus(1'b1, randBlock(), 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, randBlock(), 1'b0, 1'b1, 1'b1);
    checkOutput("flushBeatMask", 128'(out_mask), 128'h7);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);

    for (int k = 0; k < 64; k++) applyStimulus(1'b1, randBlock(), 1'b0, 1'b0, 1'b0);
    checkOutput("stallReady", 128'(in_ready), 128'(0));
    applyStimulus(1'b1, randBlock(), 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
    checkOutput("stallRelease", 128'(in_ready), 128'(1));
    checkOutput("stallSecond", 128'(out_valid), 128'(1));
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);

    for (int c = 0; c < 600; c++)
      applyStimulus(1'($urandom_range(0, 3) != 0), randBlock(),
                    1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 15) == 0),
                    1'($urandom_range(0, 1)));
    for (int c = 0; c < 3; c++) applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);

    for (int k = 0; k < 3; k++) applyStimulus(1'b1, randBlock(), (k == 2), 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) applyStimulus(1'b1, randBlock(), 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("midRstValid", 128'(out_valid), 128'(0));
    checkOutput("midRstMask", 128'(out_mask), 128'(0));
    checkOutput("midRstLast", 128'(out_last), 128'(0));
    checkOutput("midRstReady", 128'(in_ready), 128'(1));
    checkWord("midRstData", '0);
    expQ.delete();
    curBlocks.delete();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 32; k++) applyStimulus(1'b1, randBlock(), 1'b0, 1'b0, 1'b1);
    checkOutput("freshMask", 128'(out_mask), 128'hFFFF_FFFF);
    for (int c = 0; c < 3; c++) applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
